// File: rtl/spi_master_core.sv
// spi_master_core -- 8-bit full-duplex SPI master shift engine.
//
// Takes a latched CONFIG byte, TX byte and start strobe from the APB
// register stage, runs one MSB-first transfer on one of four slave selects,
// and returns the received byte with DONE / RX_VALID / OVERRUN status.
// SCK is PCLK divided by 2^(SCKsel+1); a transfer is SETUP (H cycles),
// SHIFT (16 SCK edges plus one trailing half-period), HOLD (H cycles).
//
// Build option:
//   SPI_LOOPBACK_EN  when defined, the serial input is taken from o_MOSI
//                    and i_MISO is ignored (bring-up / self-test).
//
// Ports:
//   i_PCLK      system clock, rising edge
//   i_PRESET    synchronous active-high reset
//   i_CONFIG    [5] CPOL, [4] CPHA, [3:2] slave index, [1:0] SCK select
//   i_TX_DATA   byte to transmit
//   i_START     one-cycle start strobe (ignored while busy)
//   i_RX_READ   one-cycle strobe: RX register read, clears status flags
//   i_MISO      serial data from slave
//   o_SCK       serial clock
//   o_MOSI      serial data to slave
//   o_SS_n      active-low slave selects
//   o_RX_DATA   last completed received byte
//   o_BUSY      transfer in progress
//   o_DONE      one-cycle completion pulse
//   o_RX_VALID  sticky: RX byte not yet read
//   o_OVERRUN   sticky: a byte completed while RX_VALID was still set
module spi_master_core #(
  parameter int DATA_W = 8,
  parameter int SS_N   = 4
) (
  input  logic              i_PCLK,
  input  logic              i_PRESET,
  input  logic [7:0]        i_CONFIG,
  input  logic [DATA_W-1:0] i_TX_DATA,
  input  logic              i_START,
  input  logic              i_RX_READ,
  input  logic              i_MISO,
  output logic              o_SCK,
  output logic              o_MOSI,
  output logic [SS_N-1:0]   o_SS_n,
  output logic [DATA_W-1:0] o_RX_DATA,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_RX_VALID,
  output logic              o_OVERRUN
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              cpol_q, cpha_q;
  logic [1:0]        slave_q, sck_sel_q;
  logic [2:0]        div_q;
  logic [2:0]        half_m1;
  logic [EW-1:0]     edge_cnt_q;
  logic              sck_q, mosi_q, done_q;
  logic              rx_valid_q, overrun_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] tx_sr_q, rx_sr_q;

  logic tick, start_acc, edge_ev, edge_odd, drive_ev, sample_ev, complete;
  logic serial_in;

  logic [1:0] unused_cfg;
  assign unused_cfg = i_CONFIG[7:6];

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = i_MISO;
  assign serial_in   = mosi_q;
`else
  assign serial_in   = i_MISO;
`endif

  // Half-period length minus one, from the latched SCK select.
  always_comb begin
    half_m1 = 3'd0;
    case (sck_sel_q)
      2'd0:    half_m1 = 3'd0;
      2'd1:    half_m1 = 3'd1;
      2'd2:    half_m1 = 3'd3;
      default: half_m1 = 3'd7;
    endcase
  end

  assign tick      = (div_q == half_m1);
  assign start_acc = i_START && (state_q == ST_IDLE);
  // SCK edges: one leaving SETUP, then 15 more inside SHIFT. The last
  // half-period of SHIFT (edge count already 16) produces no edge.
  assign edge_ev   = tick && ((state_q == ST_SETUP) ||
                              ((state_q == ST_SHIFT) && (edge_cnt_q != EW'(EDGES))));
  // The edge about to happen is odd (leading) when an even number are done.
  assign edge_odd  = ~edge_cnt_q[0];
  assign drive_ev  = edge_ev && (edge_odd == cpha_q);
  assign sample_ev = edge_ev && (edge_odd != cpha_q);
  assign complete  = tick && (state_q == ST_HOLD);

  // State register
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_START) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && (edge_cnt_q == EW'(EDGES))) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_BUSY     = (state_q != ST_IDLE);
    o_SS_n     = '1;
    if (state_q != ST_IDLE) o_SS_n = ~(SS_N'(1) << slave_q);
    o_SCK      = sck_q;
    o_MOSI     = mosi_q;
    o_RX_DATA  = rx_data_q;
    o_DONE     = done_q;
    o_RX_VALID = rx_valid_q;
    o_OVERRUN  = overrun_q;
  end

  // Control and status registers
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      slave_q    <= 2'd0;
      sck_sel_q  <= 2'd0;
      div_q      <= 3'd0;
      edge_cnt_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      done_q <= complete;
      if (start_acc) begin
        cpol_q     <= i_CONFIG[5];
        cpha_q     <= i_CONFIG[4];
        slave_q    <= i_CONFIG[3:2];
        sck_sel_q  <= i_CONFIG[1:0];
        div_q      <= 3'd0;
        edge_cnt_q <= '0;
        sck_q      <= i_CONFIG[5];
        // CPHA=0 presents bit7 for the whole SETUP; CPHA=1 drives it at edge 1.
        mosi_q     <= i_CONFIG[4] ? 1'b0 : i_TX_DATA[DATA_W-1];
      end else if (state_q != ST_IDLE) begin
        div_q <= tick ? 3'd0 : div_q + 3'd1;
        if (edge_ev) begin
          edge_cnt_q <= edge_cnt_q + EW'(1);
          sck_q      <= ~sck_q;
        end
        if (drive_ev) mosi_q <= tx_sr_q[DATA_W-1];
        if (complete) mosi_q <= 1'b0;
      end
      // Completion takes priority over a coincident RX read.
      if (complete) begin
        rx_data_q  <= rx_sr_q;
        rx_valid_q <= 1'b1;
        overrun_q  <= i_RX_READ ? 1'b0 : (overrun_q | rx_valid_q);
      end else if (i_RX_READ) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
    end
  end

  // Shift registers (pure data, fully reloaded / refilled every transfer)
  always_ff @(posedge i_PCLK) begin
    if (start_acc)
      tx_sr_q <= i_CONFIG[4] ? i_TX_DATA : {i_TX_DATA[DATA_W-2:0], 1'b0};
    else if (drive_ev)
      tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
    if (sample_ev)
      rx_sr_q <= {rx_sr_q[DATA_W-2:0], serial_in};
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed testbench for spi_master_core with a behavioural SPI slave.
module tb_spi_master_core;

  logic       clk;
  logic       i_PRESET;
  logic [7:0] i_CONFIG;
  logic [7:0] i_TX_DATA;
  logic       i_START;
  logic       i_RX_READ;
  logic       miso;
  logic       o_SCK, o_MOSI;
  logic [3:0] o_SS_n;
  logic [7:0] o_RX_DATA;
  logic       o_BUSY, o_DONE, o_RX_VALID, o_OVERRUN;

  int checks = 0;
  int errors = 0;

  spi_master_core #(.DATA_W(8), .SS_N(4)) dut (
    .i_PCLK    (clk),
    .i_PRESET  (i_PRESET),
    .i_CONFIG  (i_CONFIG),
    .i_TX_DATA (i_TX_DATA),
    .i_START   (i_START),
    .i_RX_READ (i_RX_READ),
    .i_MISO    (miso),
    .o_SCK     (o_SCK),
    .o_MOSI    (o_MOSI),
    .o_SS_n    (o_SS_n),
    .o_RX_DATA (o_RX_DATA),
    .o_BUSY    (o_BUSY),
    .o_DONE    (o_DONE),
    .o_RX_VALID(o_RX_VALID),
    .o_OVERRUN (o_OVERRUN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave: shifts slv_tx out, captures MOSI into slv_rx.
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  logic       mon_cpha = 1'b0;
  logic       prev_ss_low = 1'b0;
  logic       prev_sck = 1'b0;
  logic       ss_low;
  int         edge_n = 0;
  int         lead_n = 0;
  int         bit_i = 7;
  time        t_first = 0;
  time        t_last = 0;

  always @(negedge clk) begin
    ss_low = (o_SS_n != 4'hF);
    if (ss_low && !prev_ss_low) begin
      edge_n = 0;
      lead_n = 0;
      slv_rx = 8'h00;
      bit_i  = 7;
      if (!mon_cpha) begin
        miso  = slv_tx[7];
        bit_i = 6;
      end
    end else if (ss_low && (o_SCK !== prev_sck)) begin
      edge_n++;
      if (edge_n % 2 == 1) begin
        lead_n++;
        if (lead_n == 1) t_first = $time;
        t_last = $time;
        if (!mon_cpha) slv_rx = {slv_rx[6:0], o_MOSI};
        else if (bit_i >= 0) begin
          miso = slv_tx[bit_i];
          bit_i--;
        end
      end else begin
        if (mon_cpha) slv_rx = {slv_rx[6:0], o_MOSI};
        else if (bit_i >= 0) begin
          miso = slv_tx[bit_i];
          bit_i--;
        end
      end
    end
    prev_ss_low = ss_low;
    prev_sck    = o_SCK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helper: issues one transfer, called at #1 after a clock edge.
  task automatic run_xfer(input logic [7:0] cfg, input logic [7:0] tx,
                          input logic [7:0] sb, input logic [3:0] exp_ss,
                          input bit inject,
                          output int busy_n, output int ss_bad,
                          output int done_n, output logic done_after,
                          output logic sck_setup);
    slv_tx    = sb;
    mon_cpha  = cfg[4];
    i_CONFIG  = cfg;
    i_TX_DATA = tx;
    i_START   = 1'b1;
    @(posedge clk); #1;
    i_START   = 1'b0;
    sck_setup = o_SCK;
    busy_n = 0; ss_bad = 0; done_n = 0;
    while (o_BUSY && busy_n < 2000) begin
      if (o_SS_n !== exp_ss) ss_bad++;
      if (o_DONE) done_n++;
      busy_n++;
      if (inject && busy_n == 5) begin
        i_START = 1'b1; i_CONFIG = 8'h3F; i_TX_DATA = 8'hFF;
      end else begin
        i_START = 1'b0; i_CONFIG = cfg; i_TX_DATA = tx;
      end
      @(posedge clk); #1;
    end
    i_START = 1'b0;
    done_after = o_DONE;
    if (o_DONE) done_n++;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_DONE) done_n++;
    end
  endtask

  task automatic pulse_read();
    i_RX_READ = 1'b1;
    @(posedge clk); #1;
    i_RX_READ = 1'b0;
  endtask

  task automatic test_reset();
    i_PRESET = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_PRESET = 1'b0;
    checks++; if (o_SCK !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", o_SCK); end
    checks++; if (o_MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", o_MOSI); end
    checks++; if (o_SS_n !== 4'hF) begin errors++; $display("FAIL reset_ss got %h want f", o_SS_n); end
    checks++; if (o_RX_DATA !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", o_RX_DATA); end
    checks++; if ({o_BUSY, o_DONE, o_RX_VALID, o_OVERRUN} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {o_BUSY, o_DONE, o_RX_VALID, o_OVERRUN});
    end
  endtask

  task automatic test_mode00();
    int busy_n, ss_bad, done_n;
    logic done_after, sck_setup;
    run_xfer(8'h01, 8'h55, 8'hA3, 4'hE, 1'b0, busy_n, ss_bad, done_n, done_after, sck_setup);
    checks++; if (busy_n !== 36) begin errors++; $display("FAIL m00_busy_len got %0d want 36", busy_n); end
    checks++; if (ss_bad !== 0) begin errors++; $display("FAIL m00_ss got %0d bad cycles want 0", ss_bad); end
    checks++; if (lead_n !== 8) begin errors++; $display("FAIL m00_sck_pulses got %0d want 8", lead_n); end
    checks++; if ((t_last - t_first) !== 280) begin errors++; $display("FAIL m00_sck_period span got %0t want 280", t_last - t_first); end
    checks++; if (slv_rx !== 8'h55) begin errors++; $display("FAIL m00_mosi_stream got %h want 55", slv_rx); end
    checks++; if (o_RX_DATA !== 8'hA3) begin errors++; $display("FAIL m00_rx got %h want a3", o_RX_DATA); end
    checks++; if (done_after !== 1'b1 || done_n !== 1) begin
      errors++; $display("FAIL m00_done after=%b pulses=%0d want 1/1", done_after, done_n);
    end
    checks++; if (o_RX_VALID !== 1'b1) begin errors++; $display("FAIL m00_rx_valid got %b want 1", o_RX_VALID); end
    checks++; if (sck_setup !== 1'b0 || o_SCK !== 1'b0) begin
      errors++; $display("FAIL m00_sck_idle setup=%b after=%b want 0/0", sck_setup, o_SCK);
    end
  endtask

  task automatic test_modes();
    logic [7:0] cfgs [3];
    logic [3:0] sss  [3];
    logic [7:0] sbs  [3];
    int busy_n, ss_bad, done_n;
    logic done_after, sck_setup;
    cfgs[0] = 8'h14; sss[0] = 4'hD; sbs[0] = 8'hC6;
    cfgs[1] = 8'h28; sss[1] = 4'hB; sbs[1] = 8'h39;
    cfgs[2] = 8'h3C; sss[2] = 4'h7; sbs[2] = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      run_xfer(cfgs[k], 8'h55, sbs[k], sss[k], 1'b0, busy_n, ss_bad, done_n, done_after, sck_setup);
      checks++; if (busy_n !== 18) begin errors++; $display("FAIL mode%0d_busy_len got %0d want 18", k + 1, busy_n); end
      checks++; if (ss_bad !== 0) begin errors++; $display("FAIL mode%0d_ss got %0d bad cycles want 0", k + 1, ss_bad); end
      checks++; if (sck_setup !== cfgs[k][5] || o_SCK !== cfgs[k][5]) begin
        errors++; $display("FAIL mode%0d_sck_idle setup=%b after=%b want %b", k + 1, sck_setup, o_SCK, cfgs[k][5]);
      end
      checks++; if (slv_rx !== 8'h55) begin errors++; $display("FAIL mode%0d_mosi got %h want 55", k + 1, slv_rx); end
      checks++; if (o_RX_DATA !== sbs[k]) begin errors++; $display("FAIL mode%0d_rx got %h want %h", k + 1, o_RX_DATA, sbs[k]); end
    end
  endtask

  task automatic test_overrun();
    int busy_n, ss_bad, done_n;
    logic done_after, sck_setup;
    pulse_read();
    checks++; if ({o_RX_VALID, o_OVERRUN} !== 2'b00) begin
      errors++; $display("FAIL ovr_cleared got %b want 00", {o_RX_VALID, o_OVERRUN});
    end
    run_xfer(8'h00, 8'h55, 8'h12, 4'hE, 1'b0, busy_n, ss_bad, done_n, done_after, sck_setup);
    checks++; if ({o_RX_VALID, o_OVERRUN} !== 2'b10) begin
      errors++; $display("FAIL ovr_first got %b want 10", {o_RX_VALID, o_OVERRUN});
    end
    run_xfer(8'h00, 8'h55, 8'h34, 4'hE, 1'b0, busy_n, ss_bad, done_n, done_after, sck_setup);
    checks++; if ({o_RX_VALID, o_OVERRUN} !== 2'b11) begin
      errors++; $display("FAIL ovr_second got %b want 11", {o_RX_VALID, o_OVERRUN});
    end
    checks++; if (o_RX_DATA !== 8'h34) begin errors++; $display("FAIL ovr_rx got %h want 34", o_RX_DATA); end
    pulse_read();
    checks++; if ({o_RX_VALID, o_OVERRUN} !== 2'b00) begin
      errors++; $display("FAIL ovr_read_clear got %b want 00", {o_RX_VALID, o_OVERRUN});
    end
  endtask

  task automatic test_read_race();
    int busy_n, ss_bad, done_n;
    logic done_after, sck_setup;
    run_xfer(8'h00, 8'h55, 8'h11, 4'hE, 1'b0, busy_n, ss_bad, done_n, done_after, sck_setup);
    slv_tx    = 8'h96;
    mon_cpha  = 1'b0;
    i_CONFIG  = 8'h00;
    i_TX_DATA = 8'h55;
    i_START   = 1'b1;
    @(posedge clk); #1;
    i_START = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    i_RX_READ = 1'b1;
    @(posedge clk); #1;
    i_RX_READ = 1'b0;
    checks++; if ({o_BUSY, o_DONE} !== 2'b01) begin
      errors++; $display("FAIL race_done busy/done got %b want 01", {o_BUSY, o_DONE});
    end
    checks++; if ({o_RX_VALID, o_OVERRUN} !== 2'b10) begin
      errors++; $display("FAIL race_flags got %b want 10", {o_RX_VALID, o_OVERRUN});
    end
    checks++; if (o_RX_DATA !== 8'h96) begin errors++; $display("FAIL race_rx got %h want 96", o_RX_DATA); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    int busy_n, ss_bad, done_n;
    logic done_after, sck_setup;
    run_xfer(8'h14, 8'h55, 8'h6B, 4'hD, 1'b1, busy_n, ss_bad, done_n, done_after, sck_setup);
    checks++; if (busy_n !== 18) begin errors++; $display("FAIL ign_busy_len got %0d want 18", busy_n); end
    checks++; if (ss_bad !== 0) begin errors++; $display("FAIL ign_ss got %0d bad cycles want 0", ss_bad); end
    checks++; if (slv_rx !== 8'h55) begin errors++; $display("FAIL ign_mosi got %h want 55", slv_rx); end
    checks++; if (o_RX_DATA !== 8'h6B) begin errors++; $display("FAIL ign_rx got %h want 6b", o_RX_DATA); end
    checks++; if (o_BUSY !== 1'b0 || done_n !== 1) begin
      errors++; $display("FAIL ign_no_restart busy=%b pulses=%0d want 0/1", o_BUSY, done_n);
    end
  endtask

  task automatic test_preset_mid();
    i_PRESET = 1'b1;
    @(posedge clk); #1;
    i_PRESET  = 1'b0;
    slv_tx    = 8'hFF;
    mon_cpha  = 1'b0;
    i_CONFIG  = 8'h01;
    i_TX_DATA = 8'h55;
    i_START   = 1'b1;
    @(posedge clk); #1;
    i_START = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (o_BUSY !== 1'b1) begin errors++; $display("FAIL pre_busy_mid got %b want 1", o_BUSY); end
    i_PRESET = 1'b1;
    @(posedge clk); #1;
    i_PRESET = 1'b0;
    checks++; if (o_SS_n !== 4'hF) begin errors++; $display("FAIL pre_ss got %h want f", o_SS_n); end
    checks++; if (o_BUSY !== 1'b0) begin errors++; $display("FAIL pre_busy got %b want 0", o_BUSY); end
    checks++; if (o_RX_DATA !== 8'h00) begin errors++; $display("FAIL pre_rx got %h want 00", o_RX_DATA); end
    checks++; if ({o_SCK, o_MOSI, o_DONE, o_RX_VALID} !== 4'b0000) begin
      errors++; $display("FAIL pre_outs got %b want 0000", {o_SCK, o_MOSI, o_DONE, o_RX_VALID});
    end
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({o_BUSY, o_DONE, o_RX_VALID} !== 3'b000) begin
      errors++; $display("FAIL pre_stays_idle got %b want 000", {o_BUSY, o_DONE, o_RX_VALID});
    end
  endtask

  task automatic test_loopback();
    int busy_n, ss_bad, done_n;
    logic done_after, sck_setup;
    logic [7:0] exp_rx;
`ifdef SPI_LOOPBACK_EN
    exp_rx = 8'h3C;
`else
    exp_rx = 8'h00;
`endif
    run_xfer(8'h00, 8'h3C, 8'h00, 4'hE, 1'b0, busy_n, ss_bad, done_n, done_after, sck_setup);
    checks++; if (o_RX_DATA !== exp_rx) begin errors++; $display("FAIL loopback_rx got %h want %h", o_RX_DATA, exp_rx); end
    checks++; if (slv_rx !== 8'h3C) begin errors++; $display("FAIL loopback_mosi got %h want 3c", slv_rx); end
  endtask

  initial begin
    i_PRESET  = 1'b1;
    i_CONFIG  = 8'h00;
    i_TX_DATA = 8'h00;
    i_START   = 1'b0;
    i_RX_READ = 1'b0;
    miso      = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_mode00();
    test_modes();
    test_overrun();
    test_read_race();
    test_start_ignored();
    test_preset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
# spi_master_core

SPI master shift engine sitting directly downstream of the APB register interface. It takes the latched CONFIG byte, TX byte and CMD start strobe from the register stage, runs one 8-bit full-duplex SPI transfer on one of four slave selects, and returns the RX byte plus status flags for the register stage to expose on APB reads. There is one clock domain (PCLK). SCK is derived from PCLK by a power-of-two divider.

## Interface
- DATA_W, 8, transfer width in bits; MSB first.
- SS_N, 4, number of slave-select outputs; must equal 4 (2-bit slave field).

- i_PCLK  in  1  system clock; all logic on rising edge.
- i_PRESET  in  1  synchronous, active-high reset.
- i_CONFIG  in  8  [5:4] mode (bit5 = CPOL, bit4 = CPHA), [3:2] slave index, [1:0] SCK select; [7:6] ignored.
- i_TX_DATA  in  8  byte to transmit.
- i_START  in  1  single-cycle start strobe (CMD register write with bit1 = 1).
- i_RX_READ  in  1  single-cycle strobe for an APB read of the RX register.
- i_MISO  in  1  serial data from the slave.
- o_SCK  out  1  serial clock.
- o_MOSI  out  1  serial data to the slave.
- o_SS_n  out  4  active-low slave selects; one-hot-low during a transfer.
- o_RX_DATA  out  8  last received byte.
- o_BUSY  out  1  transfer in progress.
- o_DONE  out  1  one-cycle pulse when a transfer completes.
- o_RX_VALID  out  1  sticky flag: RX byte not yet read.
- o_OVERRUN  out  1  sticky flag: a byte completed while o_RX_VALID was still set.

## Operation
- Reset values: o_SCK=0, o_MOSI=0, o_SS_n=4'b1111, o_RX_DATA=0, o_BUSY=0, o_DONE=0, o_RX_VALID=0, o_OVERRUN=0. Latched mode = 00. State = IDLE.
- Half-period H = 2^SCKsel PCLK cycles (1, 2, 4, 8). The SCK frequency is PCLK/2, /4, /8 or /16; with a 16 MHz PCLK this gives 8, 4, 2 or 1 MHz.
- States:
  - IDLE: o_SCK = latched CPOL and o_MOSI = 0. On i_START the block latches i_CONFIG and i_TX_DATA, loads the shift register and goes to SETUP.
  - SETUP: lasts H cycles. o_SS_n[slave] = 0 and o_SCK = CPOL.
  - SHIFT: 16 SCK edges, H cycles apart. The first edge occurs at the end of SETUP.
  - HOLD: lasts H cycles. o_SCK = CPOL and SS is still asserted.
  - After HOLD: return to IDLE.
- CPHA=0:
  - o_MOSI shows bit7 from SETUP entry.
  - i_MISO is sampled on leading (odd) edges.
  - MOSI advances on trailing (even) edges.
- CPHA=1:
  - MOSI advances on leading edges; bit7 appears at edge 1.
  - i_MISO is sampled on trailing edges.
- Completion, all on the edge that leaves HOLD:
  - o_RX_DATA is updated.
  - o_DONE pulses.
  - o_BUSY goes to 0.
  - o_SS_n goes to 1111.
  - o_RX_VALID is set.
  - o_OVERRUN is set if o_RX_VALID was already 1 and no i_RX_READ arrives in that cycle.
- i_RX_READ clears o_RX_VALID and o_OVERRUN.
- i_START while o_BUSY=1 is ignored. Changes to i_CONFIG or i_TX_DATA during a transfer have no effect.

## Timing
- START is sampled at edge 0. From edge 0: o_BUSY=1, SS asserted, and o_SCK takes the new CPOL.
- o_BUSY stays high for exactly 18·H cycles. Examples: H=1 gives 18 cycles, H=2 gives 36 cycles.
- o_DONE is high in the cycle after o_BUSY falls.
- A new i_START is accepted in the first cycle after completion, giving back-to-back transfers with SS deasserted for at least 1 cycle.
- i_RX_READ and completion in the same cycle: completion wins. o_RX_VALID stays 1, o_OVERRUN is not set, and o_RX_DATA holds the new byte.
- i_PRESET mid-transfer: all outputs return to their reset values on the next edge, and the partial byte is discarded (o_RX_DATA is not updated).
- The SCK divider counter is reset on START, so the timing of edge 1 is deterministic.

## Configuration
- SPI_LOOPBACK_EN defined: the sampled serial input is o_MOSI instead of i_MISO, and i_MISO is ignored. This is used for board bring-up and self-test.
- SPI_LOOPBACK_EN undefined: i_MISO is sampled, and the block has no loopback mux.

## Test plan
- Reset, then START with CONFIG=0x01 (mode 00, slave 0, H=2), TX=0x55, and i_MISO driven by a model returning 0xA3:
  - o_SS_n=1110 for 36 cycles and 8 SCK pulses of period 4.
  - MOSI bit stream 0,1,0,1,0,1,0,1.
  - o_RX_DATA=0xA3, one o_DONE pulse, o_RX_VALID=1.
- Run modes 01, 10 and 11 on slaves 1, 2 and 3 with H=1, TX=0x55:
  - SCK idles at CPOL.
  - Sampling and driving happen on the correct edges per CPHA.
  - The expected SS line is low, and RX matches the slave model each time.
- Two transfers with no i_RX_READ between them: o_OVERRUN=1 after the second. Then an i_RX_READ pulse clears both flags.
- i_START pulsed during a transfer: ignored, with no extension of o_BUSY. i_PRESET asserted 10 cycles into a transfer: o_SS_n=1111, o_BUSY=0, and o_RX_DATA unchanged.
- With SPI_LOOPBACK_EN defined and i_MISO tied to 0, TX=0x3C gives o_RX_DATA=0x3C.
